// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package pc_fetch_pkg;

    // Fetch FSM states.
    typedef enum logic [1:0] {
        StBoot,
        StFetch,
        StHold
    } fetchStateT;

    // Default first fetch address after reset.
    localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

    // Instruction value held in IF/ID while it carries no real instruction.
    localparam logic [31:0] NopInstr = 32'h0000_0000;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: instruction, its PC, PC+4 and a valid flag.
// Clear wins over load; with neither asserted the contents hold.
module ifid_reg
    import pc_fetch_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] instrIn,
    input  logic [31:0] pcIn,
    output logic [31:0] instrOut,
    output logic [31:0] pcOut,
    output logic [31:0] pcPlus4Out,
    output logic        validOut
);

    // Capture a new instruction, drop validity, or hold.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            instrOut   <= NopInstr;
            pcOut      <= 32'h0;
            pcPlus4Out <= 32'h0;
            validOut   <= 1'b0;
        end else if (clear) begin
            validOut <= 1'b0;
        end else if (load) begin
            instrOut   <= instrIn;
            pcOut      <= pcIn;
            pcPlus4Out <= pcIn + 32'd4;
            validOut   <= 1'b1;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: PC, fetch FSM, one-entry stall buffer
// and the IF/ID register. Taken branches redirect the PC and flush.
module pc_fetch_ctrl
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DefaultResetPc
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [31:0] BranchTarget,
    input  logic        Branch,
    input  logic        AluZero,
    input  logic        Stall,
    output logic        FetchReq,
    output logic [31:0] FetchAddr,
    input  logic        FetchAck,
    input  logic [31:0] InstrIn,
    output logic [31:0] IfIdInstr,
    output logic [31:0] IfIdPc,
    output logic [31:0] IfIdPcPlus4,
    output logic        IfIdValid,
    output logic        Flush
);

    // PC stays word aligned even if the parameter is not.
    localparam logic [31:0] ResetPcAligned = RESET_PC & 32'hFFFF_FFFC;

    fetchStateT  state;
    logic [31:0] pc;
    logic [31:0] bufInstr;
    logic [31:0] bufPc;
    logic        bufValid;
    logic        flushQ;
    logic        fetchReqQ;

    logic        taken;
    logic        ifidLoad;
    logic        ifidClear;
    logic [31:0] ifidInstrIn;
    logic [31:0] ifidPcIn;

    // A taken branch is ignored while booting.
    assign taken = Branch & AluZero & (state != StBoot);

    assign FetchReq  = fetchReqQ;
    assign FetchAddr = pc;
    assign Flush     = flushQ;

    // IF/ID load/clear decode; the hold buffer feeds IF/ID on leaving HOLD.
    always_comb begin
        ifidLoad    = 1'b0;
        ifidClear   = 1'b0;
        ifidInstrIn = InstrIn;
        ifidPcIn    = pc;
        if (taken) begin
            ifidClear = 1'b1;
        end else begin
            case (state)
                StFetch: begin
                    if (FetchAck && !Stall) begin
                        ifidLoad = 1'b1;
                    end else if (!FetchAck && !Stall) begin
                        ifidClear = 1'b1;
                    end
                end
                StHold: begin
                    if (!Stall && bufValid) begin
                        ifidLoad    = 1'b1;
                        ifidInstrIn = bufInstr;
                        ifidPcIn    = bufPc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Fetch FSM with PC, hold buffer and registered FetchReq/Flush.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= StBoot;
            pc        <= ResetPcAligned;
            bufInstr  <= NopInstr;
            bufPc     <= 32'h0;
            bufValid  <= 1'b0;
            flushQ    <= 1'b0;
            fetchReqQ <= 1'b0;
        end else begin
            flushQ <= 1'b0;
            if (taken) begin
                pc        <= BranchTarget & 32'hFFFF_FFFC;
                bufValid  <= 1'b0;
                flushQ    <= 1'b1;
                state     <= StFetch;
                fetchReqQ <= 1'b1;
            end else begin
                case (state)
                    StBoot: begin
                        state     <= StFetch;
                        fetchReqQ <= 1'b1;
                    end
                    StFetch: begin
                        if (FetchAck) begin
                            pc <= pc + 32'd4;
                            if (Stall) begin
                                bufInstr  <= InstrIn;
                                bufPc     <= pc;
                                bufValid  <= 1'b1;
                                state     <= StHold;
                                fetchReqQ <= 1'b0;
                            end
                        end
                    end
                    StHold: begin
                        if (!Stall) begin
                            bufValid  <= 1'b0;
                            state     <= StFetch;
                            fetchReqQ <= 1'b1;
                        end
                    end
                    default: begin
                        state     <= StBoot;
                        fetchReqQ <= 1'b0;
                    end
                endcase
            end
        end
    end

    ifid_reg uIfId (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .load       (ifidLoad),
        .clear      (ifidClear),
        .instrIn    (ifidInstrIn),
        .pcIn       (ifidPcIn),
        .instrOut   (IfIdInstr),
        .pcOut      (IfIdPc),
        .pcPlus4Out (IfIdPcPlus4),
        .validOut   (IfIdValid)
    );

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl; a second instance covers PC wrap.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] InstrKey = 32'hC0DE_0000;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [31:0] BranchTarget;
    logic        Branch;
    logic        AluZero;
    logic        Stall;
    logic        FetchAck;

    logic        fetchReq1, fetchReq2;
    logic [31:0] fetchAddr1, fetchAddr2;
    logic [31:0] instrIn1, instrIn2;
    logic [31:0] ifIdInstr1, ifIdInstr2;
    logic [31:0] ifIdPc1, ifIdPc2;
    logic [31:0] ifIdPcPlus41, ifIdPcPlus42;
    logic        ifIdValid1, ifIdValid2;
    logic        flush1, flush2;

    int numChecks = 0;
    int numErrors = 0;

    // Memory model: instruction word is derived from its address.
    assign instrIn1 = fetchAddr1 ^ InstrKey;
    assign instrIn2 = fetchAddr2 ^ InstrKey;

    always #5 Clk = ~Clk;

    pc_fetch_ctrl uDut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .BranchTarget (BranchTarget),
        .Branch       (Branch),
        .AluZero      (AluZero),
        .Stall        (Stall),
        .FetchReq     (fetchReq1),
        .FetchAddr    (fetchAddr1),
        .FetchAck     (FetchAck),
        .InstrIn      (instrIn1),
        .IfIdInstr    (ifIdInstr1),
        .IfIdPc       (ifIdPc1),
        .IfIdPcPlus4  (ifIdPcPlus41),
        .IfIdValid    (ifIdValid1),
        .Flush        (flush1)
    );

    pc_fetch_ctrl #(
        .RESET_PC (32'hFFFF_FFFC)
    ) uDutWrap (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .BranchTarget (BranchTarget),
        .Branch       (Branch),
        .AluZero      (AluZero),
        .Stall        (Stall),
        .FetchReq     (fetchReq2),
        .FetchAddr    (fetchAddr2),
        .FetchAck     (FetchAck),
        .InstrIn      (instrIn2),
        .IfIdInstr    (ifIdInstr2),
        .IfIdPc       (ifIdPc2),
        .IfIdPcPlus4  (ifIdPcPlus42),
        .IfIdValid    (ifIdValid2),
        .Flush        (flush2)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numChecks++;
        if (got !== exp) begin
            numErrors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample and drive 1 time unit after the edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkVal({tag, " FetchReq"}, {31'b0, fetchReq1}, 32'd0);
        checkVal({tag, " FetchAddr"}, fetchAddr1, 32'h0);
        checkVal({tag, " IfIdInstr"}, ifIdInstr1, 32'h0);
        checkVal({tag, " IfIdPc"}, ifIdPc1, 32'h0);
        checkVal({tag, " IfIdPcPlus4"}, ifIdPcPlus41, 32'h0);
        checkVal({tag, " IfIdValid"}, {31'b0, ifIdValid1}, 32'd0);
        checkVal({tag, " Flush"}, {31'b0, flush1}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst_n        = 1'b0;
        BranchTarget = 32'h0;
        Branch       = 1'b0;
        AluZero      = 1'b0;
        Stall        = 1'b0;
        FetchAck     = 1'b0;

        tick();
        tick();
        checkResetOutputs("reset");
        checkVal("reset wrap FetchAddr", fetchAddr2, 32'hFFFF_FFFC);

        // Release reset with ack held high.
        Rst_n    = 1'b1;
        FetchAck = 1'b1;
        tick();
        checkVal("boot FetchReq", {31'b0, fetchReq1}, 32'd1);
        checkVal("boot FetchAddr", fetchAddr1, 32'h0);
        checkVal("boot IfIdValid", {31'b0, ifIdValid1}, 32'd0);
        checkVal("boot wrap FetchAddr", fetchAddr2, 32'hFFFF_FFFC);
        tick();
        checkVal("f0 FetchAddr", fetchAddr1, 32'h4);
        checkVal("f0 IfIdPc", ifIdPc1, 32'h0);
        checkVal("f0 IfIdInstr", ifIdInstr1, 32'hC0DE_0000);
        checkVal("f0 IfIdPcPlus4", ifIdPcPlus41, 32'h4);
        checkVal("f0 IfIdValid", {31'b0, ifIdValid1}, 32'd1);
        checkVal("wrap FetchAddr", fetchAddr2, 32'h0);
        checkVal("wrap IfIdPc", ifIdPc2, 32'hFFFF_FFFC);
        checkVal("wrap IfIdPcPlus4", ifIdPcPlus42, 32'h0);
        tick();
        checkVal("f1 FetchAddr", fetchAddr1, 32'h8);
        checkVal("f1 IfIdPc", ifIdPc1, 32'h4);
        tick();
        tick();
        checkVal("f3 FetchAddr", fetchAddr1, 32'h10);
        checkVal("f3 IfIdPc", ifIdPc1, 32'hC);

        // Stall for three cycles while 0x10 is acked.
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkVal($sformatf("hold%0d FetchReq", i), {31'b0, fetchReq1}, 32'd0);
            checkVal($sformatf("hold%0d FetchAddr", i), fetchAddr1, 32'h14);
            checkVal($sformatf("hold%0d IfIdPc", i), ifIdPc1, 32'hC);
        end
        Stall = 1'b0;
        tick();
        checkVal("unhold IfIdPc", ifIdPc1, 32'h10);
        checkVal("unhold IfIdInstr", ifIdInstr1, 32'hC0DE_0010);
        checkVal("unhold IfIdValid", {31'b0, ifIdValid1}, 32'd1);
        checkVal("unhold FetchReq", {31'b0, fetchReq1}, 32'd1);
        checkVal("unhold FetchAddr", fetchAddr1, 32'h14);
        tick();
        checkVal("post FetchAddr", fetchAddr1, 32'h18);
        checkVal("post IfIdPc", ifIdPc1, 32'h14);
        tick();
        tick();
        checkVal("pre-br FetchAddr", fetchAddr1, 32'h20);

        // Taken branch while 0x20 is acked.
        Branch       = 1'b1;
        AluZero      = 1'b1;
        BranchTarget = 32'h103;
        tick();
        checkVal("br FetchAddr", fetchAddr1, 32'h100);
        checkVal("br Flush", {31'b0, flush1}, 32'd1);
        checkVal("br IfIdValid", {31'b0, ifIdValid1}, 32'd0);
        checkVal("br IfIdPc", ifIdPc1, 32'h1C);
        Branch  = 1'b0;
        AluZero = 1'b0;
        tick();
        checkVal("br+1 Flush", {31'b0, flush1}, 32'd0);
        checkVal("br+1 IfIdPc", ifIdPc1, 32'h100);
        checkVal("br+1 IfIdValid", {31'b0, ifIdValid1}, 32'd1);
        checkVal("br+1 FetchAddr", fetchAddr1, 32'h104);

        // Branch not taken when AluZero is low.
        Branch       = 1'b1;
        BranchTarget = 32'h300;
        tick();
        checkVal("nt FetchAddr", fetchAddr1, 32'h108);
        checkVal("nt Flush", {31'b0, flush1}, 32'd0);
        checkVal("nt IfIdPc", ifIdPc1, 32'h104);
        Branch = 1'b0;

        // No ack and no stall gives a bubble.
        FetchAck = 1'b0;
        tick();
        checkVal("bubble FetchAddr", fetchAddr1, 32'h108);
        checkVal("bubble IfIdValid", {31'b0, ifIdValid1}, 32'd0);
        checkVal("bubble FetchReq", {31'b0, fetchReq1}, 32'd1);
        FetchAck = 1'b1;
        tick();
        checkVal("resume IfIdPc", ifIdPc1, 32'h108);
        checkVal("resume IfIdValid", {31'b0, ifIdValid1}, 32'd1);

        // Taken branch in HOLD drops the buffered 0x10C.
        Stall = 1'b1;
        tick();
        checkVal("hb FetchReq", {31'b0, fetchReq1}, 32'd0);
        checkVal("hb FetchAddr", fetchAddr1, 32'h110);
        Branch       = 1'b1;
        AluZero      = 1'b1;
        BranchTarget = 32'h40;
        tick();
        checkVal("hb br FetchReq", {31'b0, fetchReq1}, 32'd1);
        checkVal("hb br FetchAddr", fetchAddr1, 32'h40);
        checkVal("hb br Flush", {31'b0, flush1}, 32'd1);
        checkVal("hb br IfIdValid", {31'b0, ifIdValid1}, 32'd0);
        Branch  = 1'b0;
        AluZero = 1'b0;
        Stall   = 1'b0;
        tick();
        checkVal("hb+1 IfIdPc", ifIdPc1, 32'h40);
        checkVal("hb+1 IfIdValid", {31'b0, ifIdValid1}, 32'd1);
        checkVal("hb+1 Flush", {31'b0, flush1}, 32'd0);

        // Asynchronous reset while in HOLD.
        Stall = 1'b1;
        tick();
        checkVal("ar FetchReq", {31'b0, fetchReq1}, 32'd0);
        checkVal("ar IfIdPc", ifIdPc1, 32'h40);
        #3;
        Rst_n = 1'b0;
        #1;
        checkResetOutputs("async reset");

        // Taken branch during BOOT is ignored.
        Stall        = 1'b0;
        Branch       = 1'b1;
        AluZero      = 1'b1;
        BranchTarget = 32'h200;
        tick();
        Rst_n = 1'b1;
        tick();
        checkVal("boot br FetchAddr", fetchAddr1, 32'h0);
        checkVal("boot br Flush", {31'b0, flush1}, 32'd0);
        checkVal("boot br FetchReq", {31'b0, fetchReq1}, 32'd1);
        Branch  = 1'b0;
        AluZero = 1'b0;
        tick();
        checkVal("boot br+1 IfIdPc", ifIdPc1, 32'h0);
        checkVal("boot br+1 IfIdValid", {31'b0, ifIdValid1}, 32'd1);
        checkVal("boot br+1 FetchAddr", fetchAddr1, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

endmodule
